// File: rtl/hps_uart_rx.sv
// Fabric-side UART receiver for the HPS console line: 8 data bits LSB first, optional parity,
// one stop bit, delivered through a one-entry valid/ready holding register.
module hps_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [2:0] dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic          meta_q, rs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          deliver;

  assign tick = (cnt_q == '0);

  // Handshake: a byte transfers in any cycle where rx_valid & rx_ready; rx_data is held
  // stable while rx_valid is high and the consumer has not accepted it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    par_ok_d = par_ok_q;
    fe_d     = 1'b0;
    pe_d     = 1'b0;
    deliver  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rs_q) begin
          state_d  = S_START;
          cnt_d    = HALF_M1;
          par_ok_d = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rs_q) begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d[idx_q] = rs_q;
          cnt_d          = FULL_M1;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PAR: begin
        if (tick) begin
          // Odd parity wants the XOR over data and parity bit to be 1, even wants 0.
          par_ok_d = (((^shreg_q) ^ rs_q) == (PARITY == 1));
          cnt_d    = FULL_M1;
          state_d  = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rs_q) begin
            fe_d    = 1'b1;
            state_d = S_BRK;
          end else if (!par_ok_q) begin
            pe_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BRK: begin
        if (rs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (overrun_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q   <= 1'b1;
      rs_q     <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shreg_q  <= 8'h00;
      par_ok_q <= 1'b1;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      meta_q   <= rx_i;
      rs_q     <= meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_ok_q <= par_ok_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun     = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hps_uart_rx.sv
// Directed bench for hps_uart_rx: three instances cover 8N1 at 16 clk/bit, even parity,
// and the 434 clk/bit line rate driven at +/-3% skew.
module tb_hps_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx_line;
  logic [2:0] rdy;
  logic [2:0] clr;

  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       fe0, fe1, fe2;
  logic       pe0, pe1, pe2;
  logic       ov0, ov1, ov2;
  logic [2:0] st0, st1, st2;

  hps_uart_rx #(.CLKS_PER_BIT(16), .PARITY(0)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .rx_i(rx_line[0]), .rx_data(d0), .rx_valid(v0),
    .rx_ready(rdy[0]), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
    .overrun_clr(clr[0]), .dbg_state_o(st0));

  hps_uart_rx #(.CLKS_PER_BIT(16), .PARITY(2)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .rx_i(rx_line[1]), .rx_data(d1), .rx_valid(v1),
    .rx_ready(rdy[1]), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
    .overrun_clr(clr[1]), .dbg_state_o(st1));

  hps_uart_rx #(.CLKS_PER_BIT(434), .PARITY(0)) dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .rx_i(rx_line[2]), .rx_data(d2), .rx_valid(v2),
    .rx_ready(rdy[2]), .frame_err(fe2), .parity_err(pe2), .overrun(ov2),
    .overrun_clr(clr[2]), .dbg_state_o(st2));

  // Clock and cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q2[$];
  int rise_q[$];
  int fe_cnt0 = 0, fe_cnt1 = 0, pe_cnt0 = 0, pe_cnt1 = 0, fe_cnt2 = 0;
  int rx0_cnt = 0, rx1_cnt = 0;
  logic [7:0] rx1_last = 8'h00;
  logic v0_prev = 1'b0;
  logic ignore0 = 1'b0;
  int last_start = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (fe0) fe_cnt0++;
    if (fe1) fe_cnt1++;
    if (fe2) fe_cnt2++;
    if (pe0) pe_cnt0++;
    if (pe1) pe_cnt1++;
    if (v0 && !v0_prev) rise_q.push_back(cyc);
    v0_prev = v0;
    if (v0 && rdy[0] && !ignore0) begin
      rx0_cnt++;
      e = (exp_q0.size() > 0) ? {1'b1, exp_q0.pop_front()} : 9'h000;
      check_eq("rx0_data", {23'd0, 1'b1, d0}, {23'd0, e});
    end
    if (v1 && rdy[1]) begin
      rx1_cnt++;
      rx1_last = d1;
    end
    if (v2 && rdy[2]) begin
      e = (exp_q2.size() > 0) ? {1'b1, exp_q2.pop_front()} : 9'h000;
      check_eq("rx2_data", {23'd0, 1'b1, d2}, {23'd0, e});
    end
  end

  // Driver tasks: entered and left 1 time unit after a rising edge
  task automatic hold(input int sel, input logic lvl, input int cycles);
    rx_line[sel] = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input int cpb, input logic [7:0] d,
                            input bit has_par, input logic p, input logic stop);
    logic [10:0] bits;
    int n;
    bits = {2'b11, d, 1'b0};
    if (has_par) begin
      bits[9]  = p;
      bits[10] = stop;
      n = 11;
    end else begin
      bits[9] = stop;
      n = 10;
    end
    last_start = cyc;
    for (int i = 0; i < n; i++) begin
      rx_line[sel] = bits[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t_a, t_b, r;
    rst_n = 1'b0;
    rx_line = 3'b111;
    rdy = 3'b111;
    clr = 3'b000;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_valid", v0, 0);
    check_eq("rst_data", d0, 0);
    check_eq("rst_ferr", fe0, 0);
    check_eq("rst_perr", pe0, 0);
    check_eq("rst_ovr", ov0, 0);
    check_eq("rst_state", st0, 0);
    rst_n = 1'b1;
    hold(0, 1'b1, 20);

    // Back-to-back 8N1, valid exactly 155 cycles after the start bit is driven
    exp_q0.push_back(8'hA5);
    exp_q0.push_back(8'h3C);
    send_frame(0, 16, 8'hA5, 0, 0, 1);
    t_a = last_start;
    send_frame(0, 16, 8'h3C, 0, 0, 1);
    t_b = last_start;
    hold(0, 1'b1, 40);
    check_eq("b2b_count", rx0_cnt, 2);
    check_eq("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      r = rise_q.pop_front();
      check_eq("lat_a", r - t_a, 155);
      r = rise_q.pop_front();
      check_eq("lat_b", r - t_b, 155);
    end
    rise_q.delete();
    check_eq("b2b_ferr", fe_cnt0, 0);
    check_eq("b2b_perr", pe_cnt0, 0);

    // Glitch shorter than half a bit
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 30);
    check_eq("glitch_state", st0, 0);
    check_eq("glitch_count", rx0_cnt, 2);
    check_eq("glitch_ferr", fe_cnt0, 0);
    exp_q0.push_back(8'h55);
    send_frame(0, 16, 8'h55, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("post_glitch_count", rx0_cnt, 3);

    // Framing error followed by a 40-bit break
    send_frame(0, 16, 8'h81, 0, 0, 0);
    hold(0, 1'b0, 40 * 16);
    check_eq("brk_state", st0, 5);
    hold(0, 1'b1, 40);
    check_eq("frame_ferr", fe_cnt0, 1);
    check_eq("frame_count", rx0_cnt, 3);
    check_eq("frame_state", st0, 0);
    exp_q0.push_back(8'h7E);
    send_frame(0, 16, 8'h7E, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("post_frame_count", rx0_cnt, 4);
    check_eq("post_frame_ferr", fe_cnt0, 1);

    // Even parity on dut1
    hold(1, 1'b1, 20);
    send_frame(1, 16, 8'h03, 1, 1'b0, 1);
    hold(1, 1'b1, 40);
    check_eq("par_good_count", rx1_cnt, 1);
    check_eq("par_good_data", rx1_last, 8'h03);
    check_eq("par_good_perr", pe_cnt1, 0);
    send_frame(1, 16, 8'h03, 1, 1'b1, 1);
    hold(1, 1'b1, 40);
    check_eq("par_bad_perr", pe_cnt1, 1);
    check_eq("par_bad_count", rx1_cnt, 1);
    check_eq("par_bad_ferr", fe_cnt1, 0);

    // Overrun and overrun_clr priority on dut0
    rdy[0] = 1'b0;
    send_frame(0, 16, 8'h11, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("ovr_first_valid", v0, 1);
    check_eq("ovr_first_data", d0, 8'h11);
    check_eq("ovr_first_flag", ov0, 0);
    send_frame(0, 16, 8'h22, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("ovr_hold_data", d0, 8'h11);
    check_eq("ovr_flag", ov0, 1);
    exp_q0.push_back(8'h11);
    rdy[0] = 1'b1;
    hold(0, 1'b1, 3);
    rdy[0] = 1'b0;
    check_eq("ovr_drain_valid", v0, 0);
    check_eq("ovr_drain_count", rx0_cnt, 5);
    check_eq("ovr_sticky", ov0, 1);
    clr[0] = 1'b1;
    hold(0, 1'b1, 1);
    clr[0] = 1'b0;
    check_eq("ovr_cleared", ov0, 0);
    send_frame(0, 16, 8'h33, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("ovr_third_data", d0, 8'h33);
    fork
      send_frame(0, 16, 8'h44, 0, 0, 1);
      begin
        repeat (154) @(posedge clk);
        #1;
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
      end
    join
    hold(0, 1'b1, 40);
    check_eq("ovr_clr_priority", ov0, 0);
    check_eq("ovr_drop_data", d0, 8'h33);
    exp_q0.push_back(8'h33);
    rdy[0] = 1'b1;
    hold(0, 1'b1, 3);
    check_eq("ovr_final_count", rx0_cnt, 6);

    // Baud skew on dut2: 434 clk/bit receiver, 421 and 447 clk/bit transmitter
    hold(2, 1'b1, 100);
    exp_q2.push_back(8'h00); send_frame(2, 421, 8'h00, 0, 0, 1); hold(2, 1'b1, 100);
    exp_q2.push_back(8'hFF); send_frame(2, 421, 8'hFF, 0, 0, 1); hold(2, 1'b1, 100);
    exp_q2.push_back(8'h5A); send_frame(2, 421, 8'h5A, 0, 0, 1); hold(2, 1'b1, 100);
    exp_q2.push_back(8'h00); send_frame(2, 447, 8'h00, 0, 0, 1); hold(2, 1'b1, 100);
    exp_q2.push_back(8'hFF); send_frame(2, 447, 8'hFF, 0, 0, 1); hold(2, 1'b1, 100);
    exp_q2.push_back(8'h5A); send_frame(2, 447, 8'h5A, 0, 0, 1); hold(2, 1'b1, 600);
    check_eq("skew_drained", exp_q2.size(), 0);
    check_eq("skew_ferr", fe_cnt2, 0);

    // Asynchronous reset in the middle of a frame, with held byte and overrun set
    rdy[0] = 1'b0;
    send_frame(0, 16, 8'h99, 0, 0, 1);
    hold(0, 1'b1, 20);
    send_frame(0, 16, 8'h98, 0, 0, 1);
    hold(0, 1'b1, 20);
    check_eq("pre_rst_valid", v0, 1);
    check_eq("pre_rst_ovr", ov0, 1);
    hold(0, 1'b0, 40);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", v0, 0);
    check_eq("arst_data", d0, 0);
    check_eq("arst_ovr", ov0, 0);
    check_eq("arst_state", st0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 1'b0, 48);
    hold(0, 1'b1, 160);
    ignore0 = 1'b1;
    rdy[0] = 1'b1;
    clr[0] = 1'b1;
    hold(0, 1'b1, 3);
    ignore0 = 1'b0;
    clr[0] = 1'b0;
    exp_q0.push_back(8'h6B);
    send_frame(0, 16, 8'h6B, 0, 0, 1);
    hold(0, 1'b1, 40);
    check_eq("post_rst_drained", exp_q0.size(), 0);
    check_eq("post_rst_count", rx0_cnt, 7);
    check_eq("post_rst_state", st0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
